bcd_segment_encoder: RTL and testbench



---
 rtl/bcd_segment_encoder.sv | 159 +++++++++++++++
 tb/tb_bcd_segment_encoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bcd_segment_encoder.sv
// Two-digit seven-segment front end: binary value to decimal (double-dabble) or hex glyphs,
// plus the free-running clk7s refresh clock for the downstream digit multiplexer.
module bcd_segment_encoder #(
  parameter int unsigned REFRESH_HALF = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       hex_mode,
  input  logic       load,
  output logic       busy,
  output logic       clk7s,
  output logic       a0,
  output logic       b0,
  output logic       c0,
  output logic       d0,
  output logic       e0,
  output logic       f0,
  output logic       g0,
  output logic       dp0,
  output logic       a1,
  output logic       b1,
  output logic       c1,
  output logic       d1,
  output logic       e1,
  output logic       f1,
  output logic       g1,
  output logic       dp1
);

  localparam int unsigned CW = (REFRESH_HALF > 1) ? $clog2(REFRESH_HALF) : 1;
  localparam logic [CW-1:0] REFRESH_TC = CW'(REFRESH_HALF - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state;
  logic [7:0]  shift_q;
  logic [3:0]  hund_q, tens_q, ones_q;
  logic [2:0]  iter_q;
  logic [3:0]  digit1_q, digit0_q;
  logic        ovf_q;
  logic [6:0]  seg1_q, seg0_q;
  logic        dp1_q;
  logic [CW-1:0] refresh_q;
  logic        clk7s_q;
  logic [19:0] dabble_c;

  // Active-low a..g glyph patterns for 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step: correct every BCD nibble, then shift the whole chain left.
  always_comb begin
    dabble_c = 20'd0;
    dabble_c = {add3(hund_q), add3(tens_q), add3(ones_q), shift_q} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      shift_q  <= 8'd0;
      hund_q   <= 4'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      iter_q   <= 3'd0;
      digit1_q <= 4'd0;
      digit0_q <= 4'd0;
      ovf_q    <= 1'b0;
      seg1_q   <= 7'h7F;
      seg0_q   <= 7'h7F;
      dp1_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            busy <= 1'b1;
            if (hex_mode) begin
              digit1_q <= value[7:4];
              digit0_q <= value[3:0];
              ovf_q    <= 1'b0;
              state    <= UPDATE;
            end else begin
              shift_q <= value;
              hund_q  <= 4'd0;
              tens_q  <= 4'd0;
              ones_q  <= 4'd0;
              iter_q  <= 3'd0;
              state   <= CONVERT;
            end
          end
        end
        CONVERT: begin
          {hund_q, tens_q, ones_q, shift_q} <= dabble_c;
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'd7) begin
            digit1_q <= dabble_c[15:12];
            digit0_q <= dabble_c[11:8];
            ovf_q    <= (dabble_c[19:16] != 4'd0);
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          seg1_q <= glyph(digit1_q);
          seg0_q <= glyph(digit0_q);
          dp1_q  <= ~ovf_q;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running refresh divider, independent of the conversion FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      clk7s_q   <= 1'b0;
    end else if (refresh_q == REFRESH_TC) begin
      refresh_q <= '0;
      clk7s_q   <= ~clk7s_q;
    end else begin
      refresh_q <= refresh_q + CW'(1);
    end
  end

  assign clk7s = clk7s_q;
  assign {a1, b1, c1, d1, e1, f1, g1} = seg1_q;
  assign {a0, b0, c0, d0, e0, f0, g0} = seg0_q;
  assign dp1 = dp1_q;
  assign dp0 = 1'b1;

endmodule

// File: tb/tb_bcd_segment_encoder.sv
// Scoreboard bench for bcd_segment_encoder: expected displays queued on load, popped on update.
module tb_bcd_segment_encoder;

  localparam int unsigned HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic       hex_mode = 1'b0;
  logic       load = 1'b0;
  logic       busy, clk7s;
  logic       a0, b0, c0, d0, e0, f0, g0, dp0;
  logic       a1, b1, c1, d1, e1, f1, g1, dp1;
  logic [15:0] disp;
  logic [15:0] last_disp = 16'hFFFF;
  logic [15:0] sb[$];
  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bcd_segment_encoder #(.REFRESH_HALF(HALF)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .hex_mode(hex_mode), .load(load),
    .busy(busy), .clk7s(clk7s),
    .a0(a0), .b0(b0), .c0(c0), .d0(d0), .e0(e0), .f0(f0), .g0(g0), .dp0(dp0),
    .a1(a1), .b1(b1), .c1(c1), .d1(d1), .e1(e1), .f1(f1), .g1(g1), .dp1(dp1)
  );

  always #5 clk = ~clk;

  assign disp = {a1, b1, c1, d1, e1, f1, g1, dp1, a0, b0, c0, d0, e0, f0, g0, dp0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [6:0] seg_of(input int n);
    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tbl[n];
  endfunction

  function automatic logic [15:0] model(input logic [7:0] v, input logic h);
    int hi, lo;
    logic ovf_lit;
    if (h) begin
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      ovf_lit = 1'b0;
    end else begin
      hi = (int'(v) % 100) / 10;
      lo = int'(v) % 10;
      ovf_lit = (v >= 8'd100);
    end
    return {seg_of(hi), ~ovf_lit, seg_of(lo), 1'b1};
  endfunction

  // Cycle count since reset release drives the clk7s reference.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk)
    if (chk_en && rst_n)
      chk("clk7s", 32'(clk7s), 32'((cyc / HALF) % 2));

  task automatic run_load(input logic [7:0] v, input logic h, input int inject_at, input int abort_at);
    int lat;
    logic [15:0] want;
    lat = h ? 1 : 9;
    @(negedge clk);
    value = v; hex_mode = h; load = 1'b1;
    sb.push_back(model(v, h));
    @(negedge clk);
    load = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk("abort_dark", 32'(disp), 32'hFFFF);
        chk("abort_busy", 32'(busy), 32'd0);
        void'(sb.pop_front());
        last_disp = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == lat) begin
        chk("busy_fall", 32'(busy), 32'd0);
        want = sb.pop_front();
        chk("display", 32'(disp), 32'(want));
        last_disp = want;
      end else begin
        chk("busy_hold", 32'(busy), 32'd1);
        chk("no_glitch", 32'(disp), 32'(last_disp));
      end
      if (k == inject_at) begin
        value = 8'd99; hex_mode = 1'b0; load = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_disp", 32'(disp), 32'(last_disp));
  endtask

  initial begin
    value = 8'd42; load = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_disp", 32'(disp), 32'hFFFF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clk7s", 32'(clk7s), 32'd0);
    end
    load = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_load(8'd42, 1'b0, 0, 0);
    run_load(8'd255, 1'b0, 0, 0);
    run_load(8'd0, 1'b0, 0, 0);
    run_load(8'hA7, 1'b1, 0, 0);
    run_load(8'd42, 1'b0, 2, 0);
    run_load(8'd137, 1'b0, 8, 0);
    run_load(8'h3C, 1'b1, 0, 0);
    run_load(8'd42, 1'b0, 0, 4);
    run_load(8'd42, 1'b0, 0, 0);
    run_load(8'd100, 1'b0, 0, 0);
    run_load(8'd99, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++)
      run_load(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 0);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
